// File: rtl/rr_mux_merge.sv
// Round-robin merge of N valid/ready channels into one registered output stream.
// out_sel tags each word with its source channel so a downstream demux can route it back.
module rr_mux_merge #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    logic [SELW-1:0]  last_grant;
    logic             grant_vld;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             take;
    int unsigned      idx;

    assign load_en = !out_valid || out_ready;

    // Search starts just after the last winner, so the most recently served channel goes last.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!grant_vld && in_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = SELW'(idx);
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Reset suppresses handshakes so nothing is accepted in a reset cycle.
    assign take = load_en && grant_vld && !reset;

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SELW'(N - 1);
        end else if (take) begin
            out_valid  <= 1'b1;
            out_data   <= grant_data;
            out_sel    <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
